// File: rtl/dir_rom_arbiter.sv
// rtl/dir_rom_arbiter.sv - round-robin arbiter sharing one direction-offset ROM
//
// Purpose:
//   Grants one of NUM_REQ requesters per cycle in round-robin order, drives the
//   winner's address onto the shared combinational ROM and registers the ROM
//   data into a single response slot tagged with the requester index.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req, addr       per-requester request and packed addresses
//   gnt             one-hot grant (combinational, zero during reset or stall)
//   rom_a, rom_spo  shared ROM address out / data back
//   rsp_valid/ready response handshake; rsp_id, rsp_data carry the payload
//   conflict_cnt    only when DIR_ROM_ARB_PERF_EN is defined: saturating count
//                   of unstalled cycles with two or more requests pending
//
// Build option: DIR_ROM_ARB_PERF_EN
`timescale 1ns/1ps

module dir_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 5,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_a,
    input  logic [DATA_W-1:0]         rom_spo,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
`ifdef DIR_ROM_ARB_PERF_EN
    ,
    output logic [15:0]               conflict_cnt
`endif
);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic              stall;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr_unpack
        assign addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
    end

    assign stall = rsp_valid_q & ~rsp_ready;

    // Search starts one past the last winner so a requester that keeps req
    // high is only served again after everyone else had a chance.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        gnt       = '0;
        rom_a     = '0;
        if (!stall && !rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                if (!win_found && req[idx]) begin
                    win_found = 1'b1;
                    win_idx   = idx;
                end
            end
            if (win_found) begin
                gnt[win_idx] = 1'b1;
                rom_a        = addr_arr[win_idx];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (win_found) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_idx;
            rsp_data_d  = rom_spo;
            ptr_d       = win_idx;
        end else if (!stall) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef DIR_ROM_ARB_PERF_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (!stall && ($countones(req) >= 2) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: doc/dir_rom_arbiter.md
Name: dir_rom_arbiter

Overview:
Round-robin arbiter that shares one combinational direction-offset ROM (8-bit address, 5-bit two's-complement offset) among several requesters, such as the orientation/descriptor sampling units. It grants one requester per cycle, drives the ROM address, and registers the ROM output into a response carrying the requester ID. One response slot exists, with valid/ready backpressure. Sits between the sampling units and the distributed ROM instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, ROM address width
DATA_W, 5, ROM data width (two's complement offset)
ID_W, 2, requester ID width; must equal clog2(NUM_REQ)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request; held until granted
addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as acceptance
rom_a  out  ADDR_W  address to ROM
rom_spo  in  DATA_W  ROM data (combinational return)
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  index of the requester that owns the response
rsp_data  out  DATA_W  registered ROM data, unmodified

Behaviour:
- State: ptr (ID_W bits, last granted index), rsp_valid, rsp_id, rsp_data.
- Reset (async): ptr = NUM_REQ-1, so requester 0 wins first. rsp_valid, rsp_id and rsp_data = 0. gnt = 0 while rst is high.
- stall = rsp_valid & ~rsp_ready.
- Arbitration (combinational, when ~stall): search ptr+1, ptr+2, ... with modulo-NUM_REQ wrap-around. The first asserted req wins.
- Winner outputs: gnt has a single bit set; rom_a = addr of the winner.
- No winner, or stall: gnt = 0 and rom_a = 0.
- Clock edge with a grant: rsp_valid <= 1, rsp_id <= winner, rsp_data <= rom_spo, ptr <= winner.
- Clock edge with no grant and ~stall: rsp_valid <= 0. rsp_id and rsp_data hold. ptr holds.
- Clock edge with stall: all state holds. The response stays stable until accepted.
- Latency: gnt to rsp_valid is 1 cycle. Throughput is 1 per cycle while rsp_ready is high.
- rsp_ready is sampled only when rsp_valid is high. Accepting a response and issuing a new grant may happen in the same cycle.
- A requester sees acceptance only through gnt. Dropping req before gnt withdraws the request and has no side effect.
- A requester that is granted and keeps req high re-enters arbitration and is served again only after the others have had their turn.
- Reset asserted mid-operation: the pending response is discarded immediately and arbitration restarts from requester 0.
- Values in rom_a and addr outside the ROM range cannot occur (full 8-bit range). The data path does no arithmetic.

Optional Feature:
Macro DIR_ROM_ARB_PERF_EN.
- Defined: adds output conflict_cnt, 16 bits.
  - Increments on each clock edge where two or more req bits are high and ~stall.
  - Saturates at 0xFFFF.
  - Async reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Release reset; req=0001 with addr0=0x00 → gnt=0001 that cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_data=0x08.
2. req=1111 held, addr0..3=0x09,0x18,0xFF,0x03, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles. Responses are 0x1F, 0x00, 0x19, 0x05, 0x1F with IDs 0,1,2,3,0.
3. During test 2, hold rsp_ready=0 for 2 cycles → gnt=0, rom_a=0, and rsp_valid/rsp_id/rsp_data stay stable. After rsp_ready returns to 1, the next grant goes to the following index in round-robin order; no response is lost or duplicated.
4. Assert rst asynchronously mid-stream (between clock edges) → rsp_valid=0 immediately. After release with req=1111, the first grant is to requester 0.
5. Drop all req after one grant → rsp_valid falls on the following edge and rom_a=0. The last rsp_data and rsp_id are retained.
6. With DIR_ROM_ARB_PERF_EN: 3 cycles with req=0110 and ready high, then 1 stalled cycle → conflict_cnt=3. Force the counter to 0xFFFE, then apply 3 more conflict cycles → conflict_cnt=0xFFFF (saturated).
